stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control sequencer for the stopwatch digit-counter chain (mod-10/mod-6 counters). It converts start/stop, clear and lap button levels into single-cycle events, runs a prescaler that generates the base count tick, and drives the chain's Enable and Reset inputs. It also drives a display Hold flag for lap freeze. It sits between the debounced button inputs and the least-significant counter of the chain.

Parameters:
CLK_DIV, 500000, Clock cycles per count tick (50 MHz -> 100 Hz); legal range >= 2.
CNT_W, 19, Prescaler width; must satisfy 2^CNT_W >= CLK_DIV.

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high; clears all state immediately
BtnStartStop  input  1  debounced, synchronous level, active-high
BtnClear  input  1  debounced, synchronous level, active-high
BtnLap  input  1  debounced, synchronous level, active-high
Enable  output  1  count tick to counter chain, one Clock cycle wide
CounterReset  output  1  one-cycle clear pulse to counter chain
Hold  output  1  1 = display latches frozen (lap view)
Running  output  1  1 while time is advancing (RUN or LAP)
State  output  2  current state: IDLE=00, RUN=01, PAUSE=10, LAP=11

Behaviour:
- Reset (async, any time): State=IDLE, prescaler=0, button history regs=0, Enable=0, CounterReset=0, Hold=0, Running=0. Reset mid-count aborts with no further Enable pulses.
- Edge detect: each button has a 1-bit history reg. Event = level & ~history, evaluated combinationally from the current sample. An event is consumed in that cycle. A held button produces exactly one event. The first sample after Reset with button already high counts as an event.
- Simultaneous events: priority Clear > StartStop > Lap. At most one event acts per cycle; lower-priority events in that cycle are discarded. An event that is illegal in the current state is ignored and does not unblock a lower-priority event.
- Transitions (applied at the clock edge that samples the event):
  IDLE: StartStop -> RUN. Clear -> IDLE with CounterReset pulse. Lap ignored.
  RUN: StartStop -> PAUSE. Lap -> LAP. Clear ignored.
  LAP: Lap -> RUN. StartStop -> PAUSE. Clear ignored.
  PAUSE: StartStop -> RUN. Clear -> IDLE with CounterReset pulse and prescaler := 0. Lap ignored.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0, only while State is RUN or LAP.
  - Holds its value in PAUSE, so resume keeps the sub-tick phase.
  - Forced to 0 in IDLE.
- Enable = (State in {RUN, LAP}) && (prescaler == CLK_DIV-1), decoded from registers only.
  - Exactly one pulse per CLK_DIV counting cycles.
  - The first pulse after IDLE->RUN occurs CLK_DIV cycles after the transition edge.
  - Entering PAUSE on the same edge as the wrap cycle: that cycle's Enable is still emitted, because it is decoded from pre-edge state.
- CounterReset: registered, high for exactly the one cycle following the accepted Clear edge. Never asserted by Reset.
- Hold: registered, 1 exactly while State==LAP. Counting continues underneath. Leaving LAP (to RUN or PAUSE) drops Hold on the same edge.
- Running: registered, equal to (State==RUN || State==LAP).
- Outputs are glitch-free functions of registers. No combinational path from buttons to outputs.

Test Plan:
1. CLK_DIV=4; Reset pulse, then StartStop high 1 cycle -> State=01. Enable pulses at cycles 4, 8, 12 after the edge. 12 cycles yield 3 pulses.
2. RUN with prescaler=2, StartStop pulse -> State=10, Enable stays 0 for 20 cycles. StartStop again -> first Enable 1 cycle after resume (prescaler resumes at 2->3).
3. PAUSE, Clear pulse -> State=00, CounterReset=1 for exactly 1 cycle, prescaler=0. Clear in RUN -> no CounterReset, State stays 01.
4. RUN, Lap pulse -> State=11, Hold=1, Enable cadence unchanged. Lap again -> State=01, Hold=0. In LAP, StartStop -> State=10, Hold=0.
5. In PAUSE, assert Clear, StartStop and Lap in the same cycle -> only Clear acts (State=00). BtnStartStop held high 10 cycles from IDLE -> a single transition to 01.
6. Assert Reset asynchronously between clock edges while in LAP with prescaler=3 -> outputs 0 and State=00 immediately. After Reset is released, no Enable appears until a new StartStop.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button edge detect, IDLE/RUN/PAUSE/LAP FSM,
// count-tick prescaler, and registered Enable/CounterReset/Hold/Running outputs.
module stopwatch_ctrl #(
  parameter int CLK_DIV = 500000,
  parameter int CNT_W   = 19
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       BtnStartStop,
  input  logic       BtnClear,
  input  logic       BtnLap,
  output logic       Enable,
  output logic       CounterReset,
  output logic       Hold,
  output logic       Running,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] presc, presc_nxt;
  logic             hist_ss, hist_clr, hist_lap;
  logic             ev_ss, ev_clr, ev_lap;
  logic             clear_ok;
  logic             run_nxt;

  assign ev_ss  = BtnStartStop & ~hist_ss;
  assign ev_clr = BtnClear     & ~hist_clr;
  assign ev_lap = BtnLap       & ~hist_lap;

  // A pending Clear blocks lower-priority events even when it is illegal here.
  always_comb begin
    state_nxt = state;
    clear_ok  = 1'b0;
    if (ev_clr) begin
      if (state == IDLE || state == PAUSE) begin
        state_nxt = IDLE;
        clear_ok  = 1'b1;
      end
    end else if (ev_ss) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        LAP:     state_nxt = PAUSE;
        default: state_nxt = state;
      endcase
    end else if (ev_lap) begin
      if (state == RUN)      state_nxt = LAP;
      else if (state == LAP) state_nxt = RUN;
    end
  end

  // Prescaler advances on every cycle spent in RUN/LAP, holds in PAUSE.
  always_comb begin
    presc_nxt = presc;
    if (state == RUN || state == LAP)
      presc_nxt = (presc == LAST) ? '0 : presc + CNT_W'(1);
    if (state_nxt == IDLE)
      presc_nxt = '0;
  end

  assign run_nxt = (state_nxt == RUN) || (state_nxt == LAP);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      presc        <= '0;
      hist_ss      <= 1'b0;
      hist_clr     <= 1'b0;
      hist_lap     <= 1'b0;
      Enable       <= 1'b0;
      CounterReset <= 1'b0;
      Hold         <= 1'b0;
      Running      <= 1'b0;
    end else begin
      state        <= state_nxt;
      presc        <= presc_nxt;
      hist_ss      <= BtnStartStop;
      hist_clr     <= BtnClear;
      hist_lap     <= BtnLap;
      Enable       <= run_nxt && (presc_nxt == LAST);
      CounterReset <= clear_ok;
      Hold         <= (state_nxt == LAP);
      Running      <= run_nxt;
    end
  end

  assign State = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomised and directed bench for stopwatch_ctrl against a table-driven reference model.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;
  localparam int W   = 3;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3, NONE = -1;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       BtnStartStop = 1'b0, BtnClear = 1'b0, BtnLap = 1'b0;
  logic       Enable, CounterReset, Hold, Running;
  logic [1:0] State;

  int errors = 0;
  int checks = 0;

  // Reference model: state number, counting phase, button history, clear pulse.
  int m_st = S_IDLE;
  int m_p  = 0;
  bit m_hs, m_hc, m_hl, m_cr;

  // Where each button event leads from each state (NONE = ignored there).
  int tbl_ss [4] = '{S_RUN,  S_PAUSE, S_RUN,  S_PAUSE};
  int tbl_lap[4] = '{NONE,   S_LAP,   NONE,   S_RUN};
  int tbl_clr[4] = '{S_IDLE, NONE,    S_IDLE, NONE};

  stopwatch_ctrl #(.CLK_DIV(DIV), .CNT_W(W)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .BtnStartStop (BtnStartStop),
    .BtnClear     (BtnClear),
    .BtnLap       (BtnLap),
    .Enable       (Enable),
    .CounterReset (CounterReset),
    .Hold         (Hold),
    .Running      (Running),
    .State        (State)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_counting();
    return (m_st == S_RUN) || (m_st == S_LAP);
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_p = 0; m_hs = 0; m_hc = 0; m_hl = 0; m_cr = 0;
  endtask

  task automatic model_edge(input bit s, input bit c, input bit l);
    bit es = s && !m_hs;
    bit ec = c && !m_hc;
    bit el = l && !m_hl;
    int act = NONE;
    m_hs = s; m_hc = c; m_hl = l;
    if (ec)      act = tbl_clr[m_st];
    else if (es) act = tbl_ss[m_st];
    else if (el) act = tbl_lap[m_st];
    m_cr = ec && (act != NONE);
    if (m_counting()) m_p = (m_p + 1) % DIV;
    if (act != NONE) m_st = act;
    if (m_st == S_IDLE) m_p = 0;
  endtask

  task automatic compare_all();
    check("state",     int'(State),        m_st);
    check("enable",    int'(Enable),       int'(m_counting() && m_p == DIV - 1));
    check("ctr_reset", int'(CounterReset), int'(m_cr));
    check("hold",      int'(Hold),         int'(m_st == S_LAP));
    check("running",   int'(Running),      int'(m_counting()));
  endtask

  // Drive levels, let one edge sample them, then compare on the falling edge.
  task automatic cycle(input bit s, input bit c, input bit l);
    BtnStartStop = s; BtnClear = c; BtnLap = l;
    @(posedge Clock);
    model_edge(s, c, l);
    @(negedge Clock);
    compare_all();
  endtask

  // Called just after a falling edge; reset pulse fits before the next rising edge.
  task automatic async_reset(input string tag);
    #2 Reset = 1'b1;
    #1;
    check({tag, "_state"},  int'(State),        0);
    check({tag, "_enable"}, int'(Enable),       0);
    check({tag, "_cr"},     int'(CounterReset), 0);
    check({tag, "_hold"},   int'(Hold),         0);
    check({tag, "_run"},    int'(Running),      0);
    model_reset();
    #1 Reset = 1'b0;
  endtask

  initial begin
    int n;
    int mask;

    #1 Reset = 1'b1;
    #1;
    check("rst_state",  int'(State),        0);
    check("rst_enable", int'(Enable),       0);
    check("rst_cr",     int'(CounterReset), 0);
    check("rst_hold",   int'(Hold),         0);
    check("rst_run",    int'(Running),      0);
    model_reset();
    @(negedge Clock);
    Reset = 1'b0;

    // Start, then pulses on cycles 4, 8, 12 after the start edge.
    mask = 0;
    cycle(1, 0, 0);
    check("t1_state", int'(State), S_RUN);
    for (int k = 2; k <= 12; k++) begin
      cycle(0, 0, 0);
      if (Enable) mask |= (1 << k);
    end
    check("t1_pulse_mask", mask, (1 << 4) | (1 << 8) | (1 << 12));

    // Pause with phase 2, stay silent, resume gives a tick on the first cycle.
    repeat (3) cycle(0, 0, 0);
    cycle(1, 0, 0);
    check("t2_paused", int'(State), S_PAUSE);
    n = 0;
    repeat (20) begin
      cycle(0, 0, 0);
      if (Enable) n++;
    end
    check("t2_pause_ticks", n, 0);
    cycle(1, 0, 0);
    check("t2_resume_enable", int'(Enable), 1);

    // Lap view: hold raised, cadence unchanged; leaving via Lap or StartStop.
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    check("t4_lap_state", int'(State), S_LAP);
    check("t4_lap_hold",  int'(Hold),  1);
    n = 0;
    repeat (8) begin
      cycle(0, 0, 0);
      if (Enable) n++;
    end
    check("t4_lap_ticks", n, 2);
    cycle(0, 0, 1);
    check("t4_unlap_state", int'(State), S_RUN);
    check("t4_unlap_hold",  int'(Hold),  0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    check("t4_lap_pause_state", int'(State), S_PAUSE);
    check("t4_lap_pause_hold",  int'(Hold),  0);

    // All three buttons in PAUSE: only Clear acts.
    cycle(0, 0, 0);
    cycle(1, 1, 1);
    check("t5_prio_state", int'(State),        S_IDLE);
    check("t5_prio_cr",    int'(CounterReset), 1);
    cycle(0, 0, 0);
    check("t5_cr_width",   int'(CounterReset), 0);

    // Clear while running is ignored.
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    check("t3_run_clear_state", int'(State),        S_RUN);
    check("t3_run_clear_cr",    int'(CounterReset), 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    check("t3_pause_clear", int'(State), S_IDLE);
    cycle(0, 0, 0);

    // Held StartStop from IDLE yields a single transition.
    repeat (10) cycle(1, 0, 0);
    check("t5_held_state", int'(State), S_RUN);
    cycle(0, 0, 0);

    // Async reset mid-lap at phase 3.
    cycle(0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      if (m_st == S_LAP && m_p == DIV - 1) break;
      cycle(0, 0, 0);
    end
    check("t6_pre_state", int'(State), S_LAP);
    async_reset("t6");
    n = 0;
    repeat (10) begin
      cycle(0, 0, 0);
      if (Enable) n++;
    end
    check("t6_post_ticks", n, 0);
    check("t6_post_state", int'(State), S_IDLE);

    // Random button traffic with occasional async resets.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 149) == 0) async_reset("rnd_rst");
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
